// File: rtl/instr_fetch_reader.sv
// Read-side sequencer for the instruction register: walks read_pointer over a
// burst of consecutive entries (wrapping), captures each word into a small
// output FIFO and streams it downstream over a valid/ready handshake.

package ifr_pkg;
  typedef logic [4:0] address_t;
  typedef enum logic [2:0] {ZERO, ADD, SUB, AND_OP, OR_OP, XOR_OP, SHL, SHR} opc_t;
  typedef struct packed {
    opc_t       opc;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] result;
  } instruction_t;
endpackage

module instr_fetch_reader
  import ifr_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int NUM_ENTRIES = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     base_ptr,
  input  logic [5:0]   count,
  input  logic         abort,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_word,
  output address_t     out_index,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [5:0] MAX_CNT = 6'(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    instruction_t word;
    address_t     index;
    logic         last;
  } entry_t;

  state_t        state;
  logic [5:0]    remaining;
  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill;
  entry_t        head;
  logic          full, push, pop;

  assign head = mem[rd_ptr];
  assign full = (fill == CW'(FIFO_DEPTH));
  assign pop  = out_valid && out_ready;
  // A same-cycle pop frees a slot, so a full FIFO never stalls a draining consumer.
  assign push = (state == FETCH) && (!full || pop);

  // Outputs are forced to zero while empty so flushed/stale entries never leak.
  assign out_valid = (fill != '0);
  assign out_word  = out_valid ? head.word  : '0;
  assign out_index = out_valid ? head.index : '0;
  assign out_last  = out_valid ? head.last  : 1'b0;
  assign busy      = (state != IDLE);

  // FIFO storage: data only, validity tracked by fill so no reset needed here.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{word: instruction_word, index: read_pointer,
                               last: (remaining == 6'd1)};
  end

  // Sequencer FSM plus FIFO pointer/occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push && !pop)      fill <= fill + CW'(1);
      else if (pop && !push) fill <= fill - CW'(1);

      case (state)
        IDLE: begin
          if (start && count != '0) begin
            state        <= FETCH;
            read_pointer <= base_ptr;
            remaining    <= (count > MAX_CNT) ? MAX_CNT : count;
          end
        end
        FETCH: begin
          if (push) begin
            read_pointer <= (read_pointer == address_t'(NUM_ENTRIES - 1)) ? '0
                                                                         : read_pointer + 5'd1;
            remaining    <= remaining - 6'd1;
            if (remaining == 6'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Abort overrides everything above: drop the burst and empty the FIFO.
      if (abort && state != IDLE) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
        done   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/instr_fetch_reader.md
Name: instr_fetch_reader

Overview:
- Read-side sequencer for the 32-entry instruction register.
- On a start command it walks `read_pointer` from a base address over N consecutive entries, with wrap-around modulo 32.
- Each word arriving combinationally on `instruction_word` is captured into a 2-entry output FIFO.
- Words stream to a downstream consumer (checker/scoreboard/execute stage) over a valid/ready handshake with backpressure.

Parameters:
- FIFO_DEPTH, 2, output buffer depth in words (legal values 2 or 4).
- NUM_ENTRIES, 32, register-file depth; `read_pointer` wraps modulo NUM_ENTRIES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; launches a burst when idle.
- base_ptr  input  address_t (5)  first entry to read; sampled with start.
- count  input  6  entries to read, 1..32; sampled with start.
- abort  input  1  cancels the burst and flushes the FIFO.
- read_pointer  output  address_t (5)  address to the instruction register.
- instruction_word  input  instruction_t  word at `read_pointer`, combinational, same cycle.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_word  output  instruction_t  FIFO head word (opc, op_a, op_b, result).
- out_index  output  address_t (5)  register address the head word came from.
- out_last  output  1  head is the final word of the burst.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset (reset_n==0 at an edge):
  - state=IDLE, read_pointer=0, FIFO emptied.
  - out_valid=0, out_word='0 (opc ZERO), out_index=0, out_last=0, busy=0, done=0.
  - Takes priority over start and abort.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start && count!=0 -> FETCH; read_pointer<=base_ptr, remaining<=count.
  - start with count==0 is ignored: no busy, no done.
  - count>32 is clamped to 32.
- FETCH:
  - Capture: on each edge with the FIFO not full (or becoming not full through a same-cycle pop), push {instruction_word, read_pointer, last=(remaining==1)}.
  - Then read_pointer<=(read_pointer+1) mod 32 and remaining decrements.
  - FIFO full with no pop: read_pointer and remaining hold (stall).
  - Push of the final word (remaining==1) -> DRAIN.
- DRAIN:
  - No further captures; read_pointer holds its last incremented value.
  - When the out_last word handshakes (out_valid && out_ready) -> IDLE, done=1 for exactly that following cycle.
- Latency:
  - First word is valid out the cycle after start's edge plus one; first push occurs on the edge after entering FETCH.
  - Throughput is 1 word/cycle with out_ready held high.
- FIFO:
  - Push and pop in the same cycle is legal when full: count unchanged, no stall.
  - out_* show the head, stable while out_valid && !out_ready.
  - Ordering is strictly by address sequence.
- Wrap-around: base 30, count 4 reads 30, 31, 0, 1.
- start while busy: ignored, and parameters are not resampled.
- abort:
  - In FETCH or DRAIN -> IDLE next edge, FIFO flushed, out_valid=0, no done pulse.
  - Ignored in IDLE.
  - abort and start in the same cycle in IDLE: start wins.
- Reset mid-burst: same as power-on reset, with no done pulse.
- Words are passed through unmodified; the block never recomputes result.

Test Plan:
- Reset, then start base=0 count=4, out_ready=1 -> read_pointer 0,1,2,3 on successive cycles; out_index 0..3 on consecutive cycles; out_last only on index 3; done pulses once the cycle after index 3 handshakes; busy low after.
- Preload entry 5 = {ADD, 7, 3, 10}, start base=5 count=1 -> out_word {ADD, 7, 3, 10}, out_index 5, out_last=1, done once.
- start base=30 count=4 -> out_index sequence 30, 31, 0, 1; final read_pointer=2.
- start base=0 count=8, out_ready low for 6 cycles then high -> exactly 2 words buffered, read_pointer stalls at 2; all 8 words delivered in order 0..7 with no loss or duplication.
- Mid-burst after 3 handshakes of a count=10 burst, assert abort -> out_valid=0 next cycle, busy=0, no done; a following start base=12 count=2 yields indices 12, 13 only.
- start count=0 -> no busy, no done; start pulse while busy -> ignored, original burst completes unchanged; reset_n low mid-burst -> all outputs at reset values next cycle.
